// File: rtl/boid_draw_pkg.sv
// boid_draw_pkg: shared state encoding and screen geometry for the boid sprite writer.
package boid_draw_pkg;
    typedef enum logic [1:0] {IDLE, ERASE, DRAW, STEP} state_t;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int PIX_ADDR_W = 19;
endpackage

// File: rtl/boid_pix_addr.sv
// boid_pix_addr: maps sprite base col/row plus pixel index k to a framebuffer address and a clip flag.
module boid_pix_addr
    import boid_draw_pkg::*;
#(
    parameter int SIZE = 2,
    parameter int ADDR_W = PIX_ADDR_W
) (
    input  logic [15:0]       i_col,
    input  logic [15:0]       i_row,
    input  logic [3:0]        i_k,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_clip
);
    logic [16:0] w_c;
    logic [16:0] w_r;
    // one extra bit keeps base+offset from wrapping back onto the screen
    assign w_c = {1'b0, i_col} + 17'(i_k % SIZE);
    assign w_r = {1'b0, i_row} + 17'(i_k / SIZE);
    assign o_clip = (w_c >= 17'(SCREEN_W)) || (w_r >= 17'(SCREEN_H));
    assign o_addr = (ADDR_W'(w_r) << 9) + (ADDR_W'(w_r) << 7) + ADDR_W'(w_c);
endmodule

// File: rtl/boid_drawer.sv
// boid_drawer: per frame tick, optionally erases the old sprite, draws the new one, then pulses step.
// Define BOID_DRAWER_ERASE_EN to erase the previous sprite; otherwise sprites leave trails.
module boid_drawer
    import boid_draw_pkg::*;
#(
    parameter int          SIZE     = 2,
    parameter logic [7:0]  COLOR    = 8'hFF,
    parameter logic [7:0]  BG_COLOR = 8'h00,
    parameter int          ADDR_W   = PIX_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       x,
    input  logic [31:0]       y,
    input  logic [31:0]       px,
    input  logic [31:0]       py,
    output logic              busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    input  logic              wr_ready,
    output logic              step,
    output logic              done
);
    localparam logic [3:0] LAST = 4'(SIZE * SIZE - 1);
    state_t r_state;
    state_t w_state;
    logic [3:0] r_k;
    logic [3:0] w_k;
    logic [15:0] r_x;
    logic [15:0] r_y;
    logic [15:0] w_col;
    logic [15:0] w_row;
    logic w_adv;
    logic w_pix;
    logic w_clip;
    logic [ADDR_W-1:0] w_addr;
`ifdef BOID_DRAWER_ERASE_EN
    localparam state_t FIRST = ERASE;
    logic [15:0] r_px;
    logic [15:0] r_py;
    logic w_unused;
    assign w_unused = ^{x[15:0], y[15:0], px[15:0], py[15:0]};
`else
    localparam state_t FIRST = DRAW;
    logic w_unused;
    assign w_unused = ^{x[15:0], y[15:0], px, py};
`endif
    // a pixel retires when it was clipped (wr_en low) or its write was accepted
    assign w_adv = (r_state == ERASE || r_state == DRAW) && (!wr_en || wr_ready);
    assign w_pix = (w_state == ERASE) || (w_state == DRAW);
    always_comb begin
        w_state = r_state;
        w_k = r_k;
        if (r_state == IDLE && start) begin
            w_state = FIRST;
            w_k = '0;
        end else if (r_state == STEP) begin
            w_state = IDLE;
        end else if (w_adv) begin
            w_k = (r_k == LAST) ? '0 : r_k + 4'd1;
            if (r_k == LAST) w_state = (r_state == ERASE) ? DRAW : STEP;
        end
    end
    // outputs are registered, so address the pixel of the next state; in IDLE the latches are not loaded yet
    always_comb begin
        w_col = (r_state == IDLE) ? x[31:16] : r_x;
        w_row = (r_state == IDLE) ? y[31:16] : r_y;
`ifdef BOID_DRAWER_ERASE_EN
        if (w_state == ERASE) begin
            w_col = (r_state == IDLE) ? px[31:16] : r_px;
            w_row = (r_state == IDLE) ? py[31:16] : r_py;
        end
`endif
    end
    boid_pix_addr #(.SIZE(SIZE), .ADDR_W(ADDR_W)) u_addr (
        .i_col  (w_col),
        .i_row  (w_row),
        .i_k    (w_k),
        .o_addr (w_addr),
        .o_clip (w_clip)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_k <= '0;
            r_x <= '0;
            r_y <= '0;
`ifdef BOID_DRAWER_ERASE_EN
            r_px <= '0;
            r_py <= '0;
`endif
            busy <= 1'b0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            step <= 1'b0;
            done <= 1'b0;
        end else begin
            r_state <= w_state;
            r_k <= w_k;
            if (r_state == IDLE && start) begin
                r_x <= x[31:16];
                r_y <= y[31:16];
`ifdef BOID_DRAWER_ERASE_EN
                r_px <= px[31:16];
                r_py <= py[31:16];
`endif
            end
            busy <= w_state != IDLE;
            wr_en <= w_pix && !w_clip;
            if (w_pix) begin
                wr_addr <= w_addr;
                wr_data <= (w_state == ERASE) ? BG_COLOR : COLOR;
            end
            step <= w_state == STEP;
            done <= w_state == STEP;
        end
    end
endmodule

// File: tb/tb_boid_drawer.sv
// tb_boid_drawer: table-driven and randomized checks of boid_drawer against a pixel-list model.
module tb_boid_drawer;
    localparam int SIZE = 2;
`ifdef BOID_DRAWER_ERASE_EN
    localparam int ERASE = 1;
`else
    localparam int ERASE = 0;
`endif
    localparam int NPIX = SIZE * SIZE;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic wr_ready = 1'b1;
    logic [31:0] x = '0, y = '0, px = '0, py = '0;
    logic busy, wr_en, step, done;
    logic [18:0] wr_addr;
    logic [7:0] wr_data;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    boid_drawer #(.SIZE(SIZE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .x(x), .y(y), .px(px), .py(py),
        .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .step(step), .done(done)
    );

    typedef struct {
        int addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    typedef struct {
        logic [31:0] x, y, px, py;
        int st_idx;
        int st_len;
        int restart;
        int done_cyc;
        int first_draw;
    } vec_t;
    vec_t tbl[5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    function automatic void sprite(input int c0, input int r0, input logic [7:0] d);
        for (int r = r0; r < r0 + SIZE; r++)
            for (int c = c0; c < c0 + SIZE; c++)
                if (c < 640 && r < 480) exp_q.push_back('{r * 640 + c, d});
    endfunction

    function automatic void build(input logic [31:0] ix, iy, ipx, ipy);
        exp_q.delete();
        if (ERASE != 0) sprite(int'(ipx[31:16]), int'(ipy[31:16]), 8'h00);
        sprite(int'(ix[31:16]), int'(iy[31:16]), 8'hFF);
    endfunction

    // st_idx >= 0: stall that write st_len cycles; -1: random stalls; -2: no stalls
    task automatic run(input string nm, input vec_t v);
        int stalls[$];
        int acc = 0, cyc = 0, done_cyc = -1, first_draw = -1, nwr, req_done;
        logic idle_bad = 1'b0;
        build(v.x, v.y, v.px, v.py);
        nwr = exp_q.size();
        req_done = 1 + (1 + ERASE) * NPIX;
        for (int j = 0; j < nwr; j++) begin
            stalls.push_back(j == v.st_idx ? v.st_len : (v.st_idx == -1 ? int'($urandom_range(0, 2)) : 0));
            req_done += stalls[j];
        end
        if (v.done_cyc > 0) req_done = v.done_cyc;
        @(negedge clk);
        x = v.x; y = v.y; px = v.px; py = v.py;
        start = 1'b1;
        while (cyc < 60) begin
            @(negedge clk);
            cyc++;
            start = (cyc == v.restart);
            if (cyc == 2) begin
                x = $urandom; y = $urandom; px = $urandom; py = $urandom;
            end
            wr_ready = 1'b1;
            if (wr_en && acc < nwr && stalls[acc] > 0) begin
                wr_ready = 1'b0;
                stalls[acc]--;
            end
            #1;
            if (wr_en) begin
                if (acc >= nwr) chk({nm, " extra write"}, 32'(wr_addr), 32'hFFFF_FFFF);
                else begin
                    chk({nm, " addr"}, 32'(wr_addr), 32'(exp_q[acc].addr));
                    chk({nm, " data"}, 32'(wr_data), 32'(exp_q[acc].data));
                end
                if (wr_ready) begin
                    if (first_draw < 0 && wr_data == 8'hFF) first_draw = int'(wr_addr);
                    acc++;
                end
            end
            if (done) begin
                chk({nm, " step with done"}, 32'(step), 1);
                done_cyc = cyc;
                break;
            end
            chk({nm, " busy"}, 32'(busy), 1);
        end
        start = 1'b0;
        wr_ready = 1'b1;
        chk({nm, " done cycle"}, done_cyc, req_done);
        chk({nm, " write count"}, acc, nwr);
        if (v.first_draw >= 0) chk({nm, " first draw addr"}, first_draw, v.first_draw);
        @(negedge clk);
        chk({nm, " busy after done"}, 32'(busy), 0);
        chk({nm, " done width"}, 32'(done), 0);
        for (int i = 0; i < 2 * NPIX + 4; i++) begin
            @(negedge clk);
            idle_bad |= wr_en | busy;
        end
        chk({nm, " stays idle"}, 32'(idle_bad), 0);
    endtask

    initial begin
        logic flag;
        vec_t rv;
        tbl[0] = '{180 << 16, 200 << 16, 176 << 16, 196 << 16, -2, 0, -1, ERASE ? 9 : 5, 128180};
        tbl[1] = '{180 << 16, 200 << 16, 176 << 16, 196 << 16, ERASE ? 4 : 0, 3, -1, ERASE ? 12 : 8, 128180};
        tbl[2] = '{639 << 16, 479 << 16, 0, 0, -2, 0, -1, ERASE ? 9 : 5, 307199};
        tbl[3] = '{180 << 16, 200 << 16, 176 << 16, 196 << 16, -2, 0, 3, ERASE ? 9 : 5, 128180};
        tbl[4] = '{32'd638 << 16, 0, 32'hFFFF_0000, 32'hFFFF_0000, -1, 0, -1, 0, 638};

        start = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", 32'(busy), 0);
        chk("reset wr_en", 32'(wr_en), 0);
        chk("reset wr_addr", 32'(wr_addr), 0);
        chk("reset wr_data", 32'(wr_data), 0);
        chk("reset step", 32'(step), 0);
        chk("reset done", 32'(done), 0);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("start under reset ignored", 32'(busy), 0);

        for (int i = 0; i < 5; i++) run($sformatf("vec%0d", i), tbl[i]);

        @(negedge clk);
        x = 180 << 16; y = 200 << 16; px = 176 << 16; py = 196 << 16;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset busy", 32'(busy), 0);
        chk("midreset wr_en", 32'(wr_en), 0);
        chk("midreset wr_addr", 32'(wr_addr), 0);
        chk("midreset wr_data", 32'(wr_data), 0);
        chk("midreset done", 32'(done), 0);
        flag = 1'b0;
        repeat (4) begin
            @(negedge clk);
            flag |= wr_en | busy | step;
        end
        chk("midreset quiet", 32'(flag), 0);
        reset = 1'b1;
        run("post reset", tbl[0]);

        for (int i = 0; i < 20; i++) begin
            rv.x = {16'($urandom_range(0, 700)), 16'($urandom)};
            rv.y = {16'($urandom_range(0, 520)), 16'($urandom)};
            rv.px = {16'($urandom_range(0, 700)), 16'($urandom)};
            rv.py = {16'($urandom_range(0, 520)), 16'($urandom)};
            rv.st_idx = -1;
            rv.st_len = 0;
            rv.restart = (i % 3 == 0) ? int'($urandom_range(1, 4)) : -1;
            rv.done_cyc = 0;
            rv.first_draw = -1;
            run($sformatf("rand%0d", i), rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
